// File: rtl/alu_disp_pkg.sv
// ---------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display slice:
//   state_t      converter FSM states (IDLE, CONV, UPDATE)
//   NUM_DIGITS   number of displayed BCD digits
//   SEG_BLANK    all segments off (active-low)
//   SEG_TABLE    active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   seg_decode   BCD nibble -> segment pattern (blank for 10..15)
//   bcd_adjust   add-3 step of the double-dabble conversion
// ---------------------------------------------------------------------------
package alu_disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONV   = 2'd1,
      UPDATE = 2'd2
   } state_t;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry [d] holds the pattern for digit d; listed from 9 down to 0.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      if (d > 4'd9) return SEG_BLANK;
      return SEG_TABLE[d];
   endfunction

   // Every nibble >= 5 gets +3 so the following left shift carries
   // correctly into the next decimal digit. The hundreds nibble never
   // exceeds 2 for an 8-bit input, so adjusting it is harmless.
   function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
      logic [11:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_result_display_bin2bcd.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one shift-add-3 iteration per clock.
// A start seen in IDLE captures bin; eight CONV cycles follow, then one
// UPDATE cycle in which done is high and bcd holds the final digits.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   capture strobe, only honoured in IDLE
//   bin    in   8-bit unsigned value to convert
//   busy   out  high from the capture edge until the UPDATE edge (9 cycles)
//   done   out  high for the single UPDATE cycle
//   bcd    out  {hundreds, tens, units}, valid while done is high
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import alu_disp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   state_t      state;
   logic [2:0]  bit_cnt;
   logic [7:0]  bin_sr;
   logic [11:0] bcd_sr;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bin_sr  <= '0;
         bcd_sr  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_sr  <= bin;
                  bcd_sr  <= '0;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
                  state   <= CONV;
               end
            end
            CONV: begin
               {bcd_sr, bin_sr} <= {bcd_adjust(bcd_sr), bin_sr} << 1;
               bit_cnt          <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  done  <= 1'b1;
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bcd = bcd_sr;

endmodule

// File: rtl/alu_result_display.sv
// ---------------------------------------------------------------------------
// alu_result_display
// Captures the 8-bit ALU result on load, converts it to three BCD digits
// with bin2bcd_seq and drives a time-multiplexed 3-digit common-anode
// 7-segment display.
// Parameters:
//   SCAN_W    width of the scan prescaler
//   SCAN_DIV  clk cycles per digit scan slot (>= 2)
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   result  in   unsigned ALU result 0..255
//   load    in   capture strobe, ignored while a conversion runs
//   busy    out  conversion in progress
//   valid   out  display holds a converted value (sticky until reset)
//   seg     out  segments {g,f,e,d,c,b,a}, active-low
//   an      out  digit enables, active-low one-hot; an[0]=units
// Build option:
//   DISP_LZB_EN  when defined, leading zeros of hundreds/tens are blanked
// ---------------------------------------------------------------------------
module alu_result_display
   import alu_disp_pkg::*;
#(
   parameter int                SCAN_W   = 16,
   parameter logic [SCAN_W-1:0] SCAN_DIV = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] result,
   input  logic       load,
   output logic       busy,
   output logic       valid,
   output logic [6:0] seg,
   output logic [2:0] an
);

   logic                        conv_done;
   logic [11:0]                 conv_bcd;
   logic [NUM_DIGITS-1:0][3:0]  disp_q;
   logic [SCAN_W-1:0]           prescale;
   logic [1:0]                  scan_idx;
   logic [3:0]                  cur_digit;
   logic                        show_digit;

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (load),
      .bin   (result),
      .busy  (busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // The display registers are a handful of flops, not a memory, and
   // must read as zero after reset, so they share the async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q <= '0;
         valid  <= 1'b0;
      end else if (conv_done) begin
         disp_q <= conv_bcd;
         valid  <= 1'b1;
      end
   end

   // Free-running scan prescaler; each wrap moves to the next digit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale <= '0;
         scan_idx <= '0;
      end else if (prescale == SCAN_DIV - 1'b1) begin
         prescale <= '0;
         scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // NOTE: every output of this combinational block gets a default first,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cur_digit  = disp_q[scan_idx];
      show_digit = 1'b1;
`ifdef DISP_LZB_EN
      if (scan_idx == 2'd2 && disp_q[2] == 4'd0) show_digit = 1'b0;
      if (scan_idx == 2'd1 && disp_q[2] == 4'd0 && disp_q[1] == 4'd0)
         show_digit = 1'b0;
`endif
   end

   // seg and an are registered from the same index, so they switch on the
   // same edge and no digit shows its neighbour's pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg <= SEG_BLANK;
         an  <= 3'b111;
      end else if (!valid) begin
         seg <= SEG_BLANK;
         an  <= 3'b111;
      end else begin
         seg <= show_digit ? seg_decode(cur_digit) : SEG_BLANK;
         an  <= ~(3'b001 << scan_idx);
      end
   end

endmodule

// File: tb/tb_alu_result_display.sv
// ---------------------------------------------------------------------------
// tb_alu_result_display
// Scoreboard bench for alu_result_display with SCAN_DIV=4. Each accepted
// load pushes the expected three segment patterns, computed from decimal
// arithmetic; a monitor pops an entry whenever a conversion completes and
// compares the digits shown during the following scan period.
// ---------------------------------------------------------------------------
module tb_alu_result_display;

   logic       clk;
   logic       rst;
   logic [7:0] result;
   logic       load;
   logic       busy;
   logic       valid;
   logic [6:0] seg;
   logic [2:0] an;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] value;
      logic [6:0] seg_u;
      logic [6:0] seg_t;
      logic [6:0] seg_h;
   } exp_t;

   exp_t sb_q[$];

   alu_result_display #(
      .SCAN_W   (16),
      .SCAN_DIV (16'd4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .result (result),
      .load   (load),
      .busy   (busy),
      .valid  (valid),
      .seg    (seg),
      .an     (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
         3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
         6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic exp_t model(input int v);
      exp_t e;
      int h, t, u;
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      e.value = v[7:0];
      e.seg_u = seg_of(u);
      e.seg_t = seg_of(t);
      e.seg_h = seg_of(h);
`ifdef DISP_LZB_EN
      if (h == 0) e.seg_h = 7'h7F;
      if (h == 0 && t == 0) e.seg_t = 7'h7F;
`endif
      return e;
   endfunction

   // Monitor: a falling busy outside reset marks a completed conversion.
   initial begin
      logic prev_busy;
      exp_t e;
      logic [6:0] got_u, got_t, got_h;
      int bad_an;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && prev_busy && !busy) begin
            check("valid_after_update", valid, 1);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_update: conversion completed with nothing expected");
            end else begin
               e = sb_q.pop_front();
               got_u = 'x; got_t = 'x; got_h = 'x;
               bad_an = 0;
               // seg lags the display registers by one cycle.
               @(negedge clk);
               for (int i = 0; i < 13; i++) begin
                  @(negedge clk);
                  case (an)
                     3'b110: got_u = seg;
                     3'b101: got_t = seg;
                     3'b011: got_h = seg;
                     default: bad_an++;
                  endcase
               end
               check($sformatf("units_%0d", e.value), got_u, e.seg_u);
               check($sformatf("tens_%0d", e.value), got_t, e.seg_t);
               check($sformatf("hundreds_%0d", e.value), got_h, e.seg_h);
               check($sformatf("an_onehot_%0d", e.value), bad_an, 0);
            end
         end
         prev_busy = busy;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still high after %0d cycles", n);
      end
   endtask

   task automatic issue(input int v);
      @(negedge clk);
      result = v[7:0];
      load   = 1'b1;
      sb_q.push_back(model(v));
      @(negedge clk);
      load = 1'b0;
      wait_idle();
      repeat (16) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  busy,  0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_seg"},   seg,   7'h7F);
      check({tag, "_an"},    an,    3'b111);
   endtask

   initial begin
      int n_busy;
      logic [2:0] an_prev;
      int run;
      bit first_run;

      rst    = 1'b1;
      load   = 1'b0;
      result = 8'd0;

      // 1. reset state, and idle after release
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_reset_outputs("idle");

      // 2. 255: busy 9 cycles, valid at k+9
      @(negedge clk);
      result = 8'd255;
      load   = 1'b1;
      sb_q.push_back(model(255));
      @(negedge clk);
      load   = 1'b0;
      n_busy = 0;
      for (int i = 0; i < 9; i++) begin
         if (busy) n_busy++;
         if (i == 8) check("valid_before_k9", valid, 0);
         @(negedge clk);
      end
      check("busy_cycles", n_busy, 9);
      check("busy_low_k9", busy, 0);
      check("valid_k9", valid, 1);
      repeat (16) @(negedge clk);

      // 3. small value, leading-zero handling
      issue(7);

      // 4. load during conversion is ignored
      @(negedge clk);
      result = 8'd100;
      load   = 1'b1;
      sb_q.push_back(model(100));
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      result = 8'd200;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_idle();
      repeat (16) @(negedge clk);
      issue(200);

      // 6. scan order and slot length
      issue(int'($urandom_range(255)));
      an_prev   = an;
      run       = 1;
      first_run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (an == an_prev) begin
            run++;
         end else begin
            check("scan_order", an, {an_prev[1:0], an_prev[2]});
            if (!first_run) check("scan_hold", run, 4);
            first_run = 1'b0;
            run       = 1;
         end
         an_prev = an;
      end

      // 5. reset in the middle of a conversion
      @(negedge clk);
      result = 8'd123;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_mid_conv", busy, 1);
      rst = 1'b1;
      #1;
      check_reset_outputs("midconv_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check_reset_outputs("after_rst");

      // exhaustive sweep, then random values
      for (int v = 0; v < 256; v++) issue(v);
      for (int i = 0; i < 30; i++) issue(int'($urandom_range(255)));

      repeat (30) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
